// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
//   fetch PC, issues word reads to instruction memory (up to DEPTH in
//   flight), buffers the returned words with their PCs and presents one
//   instruction per cycle. A taken branch redirects fetch and drops every
//   wrong-path word, including responses still in flight.
//
// Parameters
//   RESET_PC  fetch address after reset (word aligned)
//   DEPTH     instruction buffer entries and cap on in-flight reads (2..8)
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   Stall_i               IF/ID holding, head is not consumed
//   Branch_i              taken branch resolved this cycle
//   BranchTarget_i        redirect address (bits [1:0] ignored)
//   imem_req_o/addr_o     read request and its address (the fetch PC)
//   imem_gnt_i            memory accepts the request this cycle
//   imem_rvalid_i/rdata_i in-order read response
//   PC_o, inst_o, valid_o head of the instruction buffer (inst_o = 0 when empty)
//
// Handshakes
//   A read is transferred on a rising edge where imem_req_o && imem_gnt_i.
//   imem_req_o may drop without a grant. Each transferred read produces
//   exactly one imem_rvalid_i pulse later, in request order. The head
//   instruction is consumed on an edge where valid_o && !Stall_i && !Branch_i.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic [31:0] BranchTarget_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * DEPTH + 1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // fetch PC
    logic [31:0]   r_fpc;

    // instruction buffer {PC, inst}
    logic [31:0]   r_buf_pc   [DEPTH];
    logic [31:0]   r_buf_inst [DEPTH];
    logic [PW-1:0] r_buf_rd;
    logic [PW-1:0] r_buf_wr;
    logic [CW-1:0] r_occ;

    // PCs of granted, unreturned requests
    logic [31:0]   r_addr_q [DEPTH];
    logic [PW-1:0] r_aq_rd;
    logic [PW-1:0] r_aq_wr;

    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_consume;
    logic [CW-1:0] w_load;
    logic          w_grant;
    logic          w_tracked;
    logic          w_drop;
    logic          w_accept;
    logic          w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign valid_o     = (r_occ != '0);
    assign PC_o        = valid_o ? r_buf_pc[r_buf_rd]   : 32'h0;
    assign inst_o      = valid_o ? r_buf_inst[r_buf_rd] : 32'h0;
    assign imem_addr_o = r_fpc;

    assign w_consume = valid_o && !Stall_i && !Branch_i;

    // Every word that can still arrive must have a buffer slot. The head
    // leaving this cycle already frees its slot for a response that can
    // come back at the earliest on the next edge, which keeps a 1-cycle
    // memory streaming at one instruction per cycle with DEPTH = 2.
    assign w_load     = r_occ + r_outstanding + r_discard - CW'(w_consume);
    assign imem_req_o = !rst_i && !Branch_i && (w_load < DEPTH_C);
    assign w_grant    = imem_req_o && imem_gnt_i;

    // A response with nothing tracked is ignored entirely.
    assign w_tracked = imem_rvalid_i && ((r_outstanding != '0) || (r_discard != '0));
    assign w_drop    = w_tracked && (r_discard != '0);
    assign w_accept  = w_tracked && (r_discard == '0) && !Branch_i;

    assign w_unused = ^BranchTarget_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fpc         <= RESET_PC;
            r_buf_rd      <= '0;
            r_buf_wr      <= '0;
            r_occ         <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (Branch_i) begin
            r_fpc         <= {BranchTarget_i[31:2], 2'b00};
            r_buf_rd      <= '0;
            r_buf_wr      <= '0;
            r_occ         <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
            r_outstanding <= '0;
            // Everything still in flight becomes stale. A response landing
            // in this very cycle is dropped now, so it leaves the count.
            r_discard     <= r_discard + r_outstanding - CW'(w_tracked);
        end else begin
            if (w_grant) begin
                r_fpc   <= r_fpc + 32'd4;
                r_aq_wr <= ptr_inc(r_aq_wr);
            end
            if (w_accept) begin
                r_aq_rd  <= ptr_inc(r_aq_rd);
                r_buf_wr <= ptr_inc(r_buf_wr);
            end
            if (w_consume) begin
                r_buf_rd <= ptr_inc(r_buf_rd);
            end
            r_occ         <= r_occ + CW'(w_accept) - CW'(w_consume);
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_accept);
            if (w_drop) begin
                r_discard <= r_discard - 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; occupancy and pointers qualify them.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_addr_q[r_aq_wr] <= r_fpc;
        end
        if (w_accept) begin
            r_buf_pc[r_buf_wr]   <= r_addr_q[r_aq_rd];
            r_buf_inst[r_buf_wr] <= imem_rdata_i;
        end
    end

    // Memory must only answer requests that were actually transferred.
    a_no_orphan_rvalid: assert property (
        @(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> ((r_outstanding != '0) || (r_discard != '0))
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          TB_DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Stall_i;
  logic        Branch_i;
  logic [31:0] BranchTarget_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] PC_o;
  logic [31:0] inst_o;
  logic        valid_o;

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(
    .RESET_PC (TB_RESET_PC),
    .DEPTH    (TB_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Stall_i        (Stall_i),
    .Branch_i       (Branch_i),
    .BranchTarget_i (BranchTarget_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .PC_o           (PC_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o)
  );

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_bad   = 0;
  int n_consumed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address, so a word is never
  // equal to its own PC and never zero near address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    lat_min = 1;
  int    lat_max = 1;
  int    gnt_pct = 100;
  int    mem_cyc = 0;

  initial begin : memory
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_cyc++;
      if (rst_i) mq.delete();
      if (mq.size() > 0 && mq[0].due <= mem_cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mq[0].addr);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
      @(negedge clk_i);
      if (!rst_i) begin
        if (imem_rvalid_i) void'(mq.pop_front());
        if (imem_req_o && imem_gnt_i) begin
          mreq_t r;
          r.addr = imem_addr_o;
          r.due  = mem_cyc + $urandom_range(lat_min, lat_max);
          mq.push_back(r);
        end
        check("inflight_le_depth", 32'(mq.size() <= TB_DEPTH), 32'd1);
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Expected program order of the current path: start, start+4, ...
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    exp_next = start;
  endtask

  initial begin : monitor
    logic        br_prev;
    logic [31:0] br_tgt;
    int          idle;
    br_prev = 1'b0;
    br_tgt  = 32'h0;
    idle    = 0;
    refill(TB_RESET_PC);
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        refill(TB_RESET_PC);
        br_prev = 1'b0;
        idle    = 0;
        check("req_low_in_reset", 32'(imem_req_o), 32'd0);
      end else begin
        while (exp_q.size() < 16) begin
          exp_q.push_back(exp_next);
          exp_next = exp_next + 32'd4;
        end
        if (br_prev) begin
          check("valid_after_branch", 32'(valid_o), 32'd0);
          check("addr_after_branch", imem_addr_o, br_tgt);
        end
        if (Branch_i) check("req_in_branch", 32'(imem_req_o), 32'd0);
        if (valid_o) begin
          idle = 0;
          check("head_pc", PC_o, exp_q[0]);
          check("head_inst", inst_o, mem_word(exp_q[0]));
          if (!Stall_i && !Branch_i) begin
            void'(exp_q.pop_front());
            n_consumed++;
          end
        end else begin
          idle++;
          check("bubble_inst", inst_o, 32'h0);
        end
        check("progress", 32'(idle <= 40), 32'd1);
        if (Branch_i) begin
          br_tgt  = {BranchTarget_i[31:2], 2'b00};
          br_prev = 1'b1;
          refill(br_tgt);
        end else begin
          br_prev = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_pc", PC_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, TB_RESET_PC);
  endtask

  // Reset asserted mid-cycle: outputs must clear with no clock edge.
  task automatic do_async_reset();
    @(posedge clk_i);
    #3;
    Branch_i = 1'b0;
    Stall_i  = 1'b0;
    rst_i    = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    @(posedge clk_i);
    #2;
    Stall_i        = 1'b0;
    Branch_i       = 1'b1;
    BranchTarget_i = tgt;
    @(posedge clk_i);
    #2;
    Branch_i = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    rst_i          = 1'b1;
    Stall_i        = 1'b0;
    Branch_i       = 1'b0;
    BranchTarget_i = 32'h0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;

    // 1-cycle memory, no stall: continuous stream from the second cycle.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (k >= 2) check("stream_valid", 32'(valid_o), 32'd1);
    end

    // Hold IF/ID for 3 cycles: fetch must back off.
    @(posedge clk_i);
    #2;
    Stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("stall_req_off", 32'(imem_req_o), 32'd0);
      if (k < 2) begin
        @(posedge clk_i);
        #2;
      end
    end
    @(posedge clk_i);
    #2;
    Stall_i = 1'b0;
    repeat (6) @(posedge clk_i);

    // Slow memory, then redirect with reads in flight.
    lat_min = 3;
    lat_max = 3;
    repeat (6) @(posedge clk_i);
    branch_to(32'h0000_0103);
    repeat (14) @(posedge clk_i);

    lat_min = 1;
    lat_max = 1;
    branch_to(32'h0000_0000);
    repeat (10) @(posedge clk_i);

    // Reset with reads outstanding and words buffered.
    lat_min = 2;
    lat_max = 2;
    repeat (5) @(posedge clk_i);
    do_async_reset();
    repeat (8) @(posedge clk_i);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        lat_min = $urandom_range(1, 3);
        lat_max = lat_min + $urandom_range(0, 1);
        gnt_pct = $urandom_range(50, 100);
      end
      if ($urandom_range(0, 199) == 0) begin
        do_async_reset();
      end else begin
        @(posedge clk_i);
        #2;
        Stall_i  = ($urandom_range(0, 99) < 30);
        Branch_i = ($urandom_range(0, 99) < 5);
        BranchTarget_i = $urandom;
        if ($urandom_range(0, 3) == 0) BranchTarget_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end
    end

    @(posedge clk_i);
    #2;
    Stall_i  = 1'b0;
    Branch_i = 1'b0;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("enough_consumed", 32'(n_consumed >= 100), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
